// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types and signed clamp limits for the product accumulator
package acc_pkg;

    typedef enum logic {ACCUM, DONE} acc_state_t;

    localparam int PROD_W_DEFAULT = 8;

    function automatic logic signed [31:0] acc_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] acc_min(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational signed add with clamp to ACC_W range and overflow flag
module sat_add
    import acc_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    localparam logic signed [31:0]    MAX32 = acc_max(ACC_W);
    localparam logic signed [31:0]    MIN32 = acc_min(ACC_W);
    localparam logic signed [ACC_W:0] MAX_X = MAX32[ACC_W:0];
    localparam logic signed [ACC_W:0] MIN_X = MIN32[ACC_W:0];

    logic signed [ACC_W:0] wide;

    // One guard bit is enough: the true sum of two ACC_W values always fits.
    always_comb begin
        wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        sum  = wide[ACC_W-1:0];
        ovf  = 1'b0;
        if (wide > MAX_X) begin
            sum = MAX_X[ACC_W-1:0];
            ovf = 1'b1;
        end else if (wide < MIN_X) begin
            sum = MIN_X[ACC_W-1:0];
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/signed_product_accumulator.sv
// rtl/signed_product_accumulator.sv - saturating dot-product accumulator with valid/ready on both sides
module signed_product_accumulator
    import acc_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEFAULT,
    parameter int ACC_W     = 12,
    parameter int MAX_TERMS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int             CNT_W    = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);

    acc_state_t              state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sat_sum;
    logic                    sat_ovf;
    logic                    take;
    logic                    close;

    assign prod_ext = ACC_W'($signed(in_prod));
    assign take     = in_valid && in_ready;
    // A term that is both flagged last and hits the term limit closes only once.
    assign close    = in_last || (cnt == LAST_CNT);

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (prod_ext),
        .sum (sat_sum),
        .ovf (sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    if (take) begin
                        acc <= sat_sum;
                        ovf <= ovf | sat_ovf;
                        cnt <= cnt + 1'b1;
                        if (close) begin
                            state     <= DONE;
                            out_sum   <= sat_sum;
                            out_ovf   <= ovf | sat_ovf;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // in_ready stays low through the handoff cycle, so no term bypasses the drain.
                    if (out_ready) begin
                        state     <= ACCUM;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_product_accumulator.sv
// tb/tb_signed_product_accumulator.sv - directed and randomized checks of the product accumulator
module tb_signed_product_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid_a  [2];
    logic       in_ready_a  [2];
    logic [7:0] in_prod_a   [2];
    logic       in_last_a   [2];
    logic       out_valid_a [2];
    logic       out_ready_a [2];
    logic       out_ovf_a   [2];
    logic [11:0] sum12;
    logic [7:0]  sum8;

    int checks;
    int failures;

    // Instance 0: default widths (ACC_W=12); instance 1: ACC_W=8 to reach saturation.
    signed_product_accumulator dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a[0]),
        .in_ready  (in_ready_a[0]),
        .in_prod   (in_prod_a[0]),
        .in_last   (in_last_a[0]),
        .out_valid (out_valid_a[0]),
        .out_ready (out_ready_a[0]),
        .out_sum   (sum12),
        .out_ovf   (out_ovf_a[0])
    );

    signed_product_accumulator #(.ACC_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a[1]),
        .in_ready  (in_ready_a[1]),
        .in_prod   (in_prod_a[1]),
        .in_last   (in_last_a[1]),
        .out_valid (out_valid_a[1]),
        .out_ready (out_ready_a[1]),
        .out_sum   (sum8),
        .out_ovf   (out_ovf_a[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cur_sum(input int s);
        return (s == 1) ? {24'd0, sum8} : {20'd0, sum12};
    endfunction

    function automatic logic [31:0] wmask(input int s, input int v);
        logic [31:0] m;
        m = (s == 1) ? 32'h0000_00FF : 32'h0000_0FFF;
        return v & m;
    endfunction

    task automatic put(input int s, input logic [7:0] p, input logic l);
        int n;
        n = 0;
        in_valid_a[s] = 1'b1;
        in_prod_a[s]  = p;
        in_last_a[s]  = l;
        while (in_ready_a[s] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("put_timeout", 32'd0, 32'd1);
        else @(negedge clk);
        in_valid_a[s] = 1'b0;
        in_prod_a[s]  = 'x;
        in_last_a[s]  = 'x;
    endtask

    // Called right after the closing term's accept edge: out_valid must already be high.
    task automatic get(input int s, input int exp_sum, input bit exp_ovf, input int delay, input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid_a[s]}, 32'd1);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {30'd0, out_valid_a[s], in_ready_a[s]}, 32'd2);
        end
        chk({tag, "_sum"}, cur_sum(s), wmask(s, exp_sum));
        chk({tag, "_ovf"}, {31'd0, out_ovf_a[s]}, {31'd0, exp_ovf});
        out_ready_a[s] = 1'b1;
        @(negedge clk);
        out_ready_a[s] = 1'b0;
        chk({tag, "_drain"}, {30'd0, out_valid_a[s], in_ready_a[s]}, 32'd1);
    endtask

    initial begin
        int  msum;
        bit  movf;
        int  n;
        int  s;
        int  lo;
        int  hi;
        int  sp;
        bit  l;
        bit  done;
        logic [7:0] p;
        logic [31:0] held;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_a[i]  = 1'b0;
            in_prod_a[i]   = 'x;
            in_last_a[i]   = 'x;
            out_ready_a[i] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid_a[0]}, 32'd0);
        chk("rst_out_sum", cur_sum(0), 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf_a[0]}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_a[0]}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic vector: -36 + 7 + 0 + 1 = -28
        put(0, 8'hDC, 1'b0);
        put(0, 8'h07, 1'b0);
        put(0, 8'h00, 1'b0);
        put(0, 8'h01, 1'b1);
        get(0, -28, 1'b0, 0, "basic");

        // Saturation on the narrow instance, then ovf clears for the next vector
        put(1, 8'h40, 1'b0);
        put(1, 8'h40, 1'b1);
        get(1, 127, 1'b1, 0, "sat_pos");
        put(1, 8'h01, 1'b1);
        get(1, 1, 1'b0, 0, "ovf_clear");

        // Clamp is per-add: pinned at +127, then -128 moves it to -1, ovf stays sticky
        put(1, 8'h7F, 1'b0);
        put(1, 8'h7F, 1'b0);
        put(1, 8'h80, 1'b1);
        get(1, -1, 1'b1, 0, "off_rail");

        // Negative rail reached exactly is not an overflow
        for (int i = 0; i < 16; i++) put(0, 8'h80, 1'b0);
        get(0, -2048, 1'b0, 0, "min_exact");

        // Forced close at MAX_TERMS, 17th term blocked under backpressure
        for (int i = 0; i < 16; i++) put(0, 8'h01, 1'b0);
        chk("max_valid", {31'd0, out_valid_a[0]}, 32'd1);
        chk("max_sum", cur_sum(0), 32'd16);
        held = cur_sum(0);
        in_valid_a[0] = 1'b1;
        in_prod_a[0]  = 8'h05;
        in_last_a[0]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready_a[0]}, 32'd0);
            chk("bp_sum_stable", cur_sum(0), held);
        end
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        out_ready_a[0] = 1'b0;
        chk("bp_handoff", {30'd0, out_valid_a[0], in_ready_a[0]}, 32'd1);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        in_prod_a[0]  = 'x;
        in_last_a[0]  = 'x;
        get(0, 5, 1'b0, 0, "term17");

        // in_last on the MAX_TERMS-th term closes once
        for (int i = 0; i < 15; i++) put(0, 8'h02, 1'b0);
        put(0, 8'h03, 1'b1);
        get(0, 33, 1'b0, 2, "last_at_max");
        repeat (2) begin
            @(negedge clk);
            chk("no_double_close", {31'd0, out_valid_a[0]}, 32'd0);
        end

        // Reset mid-vector discards the partial sum
        put(0, 8'd100, 1'b0);
        put(0, 8'd100, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid_a[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_quiet", {31'd0, out_valid_a[0]}, 32'd0);
        end
        put(0, 8'hFF, 1'b0);
        put(0, 8'hFF, 1'b1);
        get(0, -2, 1'b0, 0, "after_rst");

        // Reset while in DONE drops out_valid without a handshake
        put(0, 8'h11, 1'b1);
        chk("done_rst_pre", {31'd0, out_valid_a[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("done_rst_valid", {30'd0, out_valid_a[0], in_ready_a[0]}, 32'd1);
        chk("done_rst_sum", cur_sum(0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized vectors against an integer reference model
        for (int v = 0; v < 60; v++) begin
            s    = v % 2;
            hi   = (s == 1) ? 127 : 2047;
            lo   = -hi - 1;
            msum = 0;
            movf = 1'b0;
            n    = 0;
            done = 1'b0;
            while (!done) begin
                p  = 8'($urandom_range(0, 255));
                l  = ($urandom_range(0, 5) == 0);
                sp = (p > 8'd127) ? int'(p) - 256 : int'(p);
                msum = msum + sp;
                if (msum > hi) begin
                    msum = hi;
                    movf = 1'b1;
                end else if (msum < lo) begin
                    msum = lo;
                    movf = 1'b1;
                end
                n++;
                done = l || (n == 16);
                put(s, p, l);
                if (!done) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            get(s, msum, movf, $urandom_range(0, 3), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
